// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit clamp helper for the up/down counter.
package bcd_pkg;

   localparam int                 BCD_W   = 4;
   localparam logic [BCD_W-1:0]   BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0]   BCD_MIN = 4'd0;

   // Force a nibble into the legal BCD range; 10..15 become 9.
   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter: holds 0..9, steps when enabled and the
// carry/borrow from the digit below is set, and reports carry/borrow upward.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             cin_i,
   input  logic             load_i,
   input  logic [BCD_W-1:0] load_digit_i,
   output logic [BCD_W-1:0] digit_o,
   output logic             cout_o
);

   logic [BCD_W-1:0] digit_q, digit_d;

   // Carry (up) or borrow (down) leaves this digit only when it is at its limit.
   assign cout_o  = cin_i & (up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
   assign digit_o = digit_q;

   // Next digit: load wins, otherwise step only with carry/borrow in.
   always_comb begin
      digit_d = digit_q;
      if (load_i) begin
         digit_d = bcd_clamp(load_digit_i);
      end else if (en_i && cin_i) begin
         if (up_i) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
         else      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
   end

   // Digit register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) digit_q <= BCD_MIN;
      else     digit_q <= digit_d;
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with load, enable and wrap flag.
// Define BCD_CNT_SAT_EN to make the counter saturate at all-9s / all-0s instead
// of wrapping; wrap then flags every enabled cycle that pushed on the limit.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap,
   output logic                  load_err
);

   logic [DIGITS:0]   carry;
   logic [DIGITS-1:0] bad_digit;
   logic              boundary;
   logic              step_en;
   logic              wrap_q, wrap_d;
   logic              load_err_q, load_err_d;

   // Digit 0 always sees carry/borrow-in, so the top carry-out means the whole
   // count sits at the limit in the current direction.
   assign carry[0] = 1'b1;
   assign boundary = carry[DIGITS];

`ifdef BCD_CNT_SAT_EN
   assign step_en = en & ~boundary;
`else
   assign step_en = en;
`endif

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bad_digit[gi] = load_val[gi*BCD_W +: BCD_W] > BCD_MAX;

      bcd_digit u_digit (
         .clk          (clk),
         .rst          (rst),
         .en_i         (step_en),
         .up_i         (up),
         .cin_i        (carry[gi]),
         .load_i       (load),
         .load_digit_i (load_val[gi*BCD_W +: BCD_W]),
         .digit_o      (count[gi*BCD_W +: BCD_W]),
         .cout_o       (carry[gi+1])
      );
   end

   // Flags for the edge about to happen; a load suppresses wrap.
   always_comb begin
      wrap_d     = ~load & en & boundary;
      load_err_d = load & (|bad_digit);
   end

   // Flag registers, aligned with the count update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 2-digit and a 4-digit instance share control
// inputs; an integer-valued model tracks both and is compared every cycle.
module tb_bcd_updown_counter;

`ifdef BCD_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1;
   logic en = 1'b0, up = 1'b0, load = 1'b0;
   logic [7:0]  lv2 = '0, count2;
   logic [15:0] lv4 = '0, count4;
   logic wrap2, err2, wrap4, err4;

   int passed = 0, total = 0;

   bcd_updown_counter #(.DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv2),
      .count(count2), .wrap(wrap2), .load_err(err2));

   bcd_updown_counter #(.DIGITS(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv4),
      .count(count4), .wrap(wrap4), .load_err(err4));

   always #5 clk = ~clk;

   typedef struct packed { int v; bit w; bit e; } mres_t;

   // Decimal value -> packed BCD.
   function automatic logic [31:0] to_bcd(input int v, input int nd);
      logic [31:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < nd; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Model of one edge, in plain decimal arithmetic.
   function automatic mres_t mstep(input int nd, input int v, input logic [31:0] lv,
                                   input bit ld, input bit en_, input bit up_);
      mres_t r;
      int top;
      logic [3:0] d;
      top = 1;
      for (int i = 0; i < nd; i++) top = top * 10;
      top = top - 1;
      r.v = v; r.w = 1'b0; r.e = 1'b0;
      if (ld) begin
         r.v = 0;
         for (int i = nd - 1; i >= 0; i--) begin
            d = lv[i*4 +: 4];
            if (d > 4'd9) begin d = 4'd9; r.e = 1'b1; end
            r.v = r.v * 10 + int'(d);
         end
      end else if (en_) begin
         if (up_) begin
            if (v == top) begin r.w = 1'b1; r.v = SAT ? top : 0; end
            else r.v = v + 1;
         end else begin
            if (v == 0) begin r.w = 1'b1; r.v = SAT ? 0 : top; end
            else r.v = v - 1;
         end
      end
      return r;
   endfunction

   int m2 = 0, m4 = 0;
   bit mw2 = 0, me2 = 0, mw4 = 0, me4 = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m2 <= 0; mw2 <= 0; me2 <= 0;
         m4 <= 0; mw4 <= 0; me4 <= 0;
      end else begin
         mres_t a, b;
         a = mstep(2, m2, 32'(lv2), load, en, up);
         b = mstep(4, m4, 32'(lv4), load, en, up);
         m2 <= a.v; mw2 <= a.w; me2 <= a.e;
         m4 <= b.v; mw4 <= b.w; me4 <= b.e;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model comparison every cycle outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         check("cnt2",  32'(count2), to_bcd(m2, 2));
         check("wrap2", 32'(wrap2),  32'(mw2));
         check("err2",  32'(err2),   32'(me2));
         check("cnt4",  32'(count4), to_bcd(m4, 4));
         check("wrap4", 32'(wrap4),  32'(mw4));
         check("err4",  32'(err4),   32'(me4));
      end
   end

   // Drive one cycle's inputs, then wait until its result is visible.
   task automatic cyc(input bit e, input bit u, input bit l,
                      input logic [7:0] v2, input logic [15:0] v4);
      en = e; up = u; load = l; lv2 = v2; lv4 = v4;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b0;
      check("rst_cnt2", 32'(count2), 32'h0);
      check("rst_wrap2", 32'(wrap2), 32'h0);

      // Async reset between edges with count = 57.
      cyc(0, 0, 1, 8'h57, 16'h0);
      check("ld57", 32'(count2), 32'h57);
      en = 1'b0; load = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_cnt2", 32'(count2), 32'h0);
      check("arst_wrap2", 32'(wrap2), 32'h0);
      check("arst_err2", 32'(err2), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Up from 00 through 99 and across the boundary.
      for (int k = 1; k <= 101; k++) begin
         cyc(1, 1, 0, 8'h0, 16'h0);
         if (k == 37)  check("up37", 32'(count2), 32'h37);
         if (k == 99)  begin
            check("up99", 32'(count2), 32'h99);
            check("up99_wrap", 32'(wrap2), 32'h0);
         end
         if (k >= 100) begin
            check("upwrap_cnt", 32'(count2), SAT ? 32'h99 : (k == 100 ? 32'h0 : 32'h1));
            check("upwrap_flag", 32'(wrap2), (SAT || k == 100) ? 32'h1 : 32'h0);
         end
      end

      // Down from 10 through 00 and across the boundary.
      cyc(0, 0, 1, 8'h10, 16'h0);
      for (int k = 1; k <= 11; k++) begin
         cyc(1, 0, 0, 8'h0, 16'h0);
         if (k == 1)  check("dn09", 32'(count2), 32'h09);
         if (k == 10) check("dn00", 32'(count2), 32'h00);
         if (k == 11) begin
            check("dnwrap_cnt", 32'(count2), SAT ? 32'h00 : 32'h99);
            check("dnwrap_flag", 32'(wrap2), 32'h1);
         end
      end

      // Direction change takes effect on the same edge.
      cyc(0, 0, 1, 8'h05, 16'h0);
      cyc(1, 0, 0, 8'h0, 16'h0);
      cyc(1, 0, 0, 8'h0, 16'h0);
      check("dir03", 32'(count2), 32'h03);
      cyc(1, 1, 0, 8'h0, 16'h0);
      check("dir04", 32'(count2), 32'h04);

      // Load with non-BCD digit beats enable.
      cyc(1, 1, 1, 8'h3C, 16'h0);
      check("ld3c_cnt", 32'(count2), 32'h39);
      check("ld3c_err", 32'(err2), 32'h1);
      check("ld3c_wrap", 32'(wrap2), 32'h0);
      cyc(1, 1, 0, 8'h0, 16'h0);
      check("ld3c_next", 32'(count2), 32'h40);
      check("ld3c_err_clr", 32'(err2), 32'h0);

      // Four-digit ripple in both directions, then hold.
      cyc(0, 0, 1, 8'h0, 16'h0999);
      cyc(1, 1, 0, 8'h0, 16'h0);
      check("rip_up", 32'(count4), 32'h1000);
      cyc(0, 0, 1, 8'h0, 16'h1000);
      cyc(1, 0, 0, 8'h0, 16'h0);
      check("rip_dn", 32'(count4), 32'h0999);
      for (int k = 0; k < 5; k++) begin
         cyc(0, $urandom_range(0, 1) == 1, 0, 8'h0, 16'h0);
         check("hold_cnt", 32'(count4), 32'h0999);
         check("hold_wrap", 32'(wrap4), 32'h0);
      end

      // Randomized traffic with boundary-biased loads.
      for (int k = 0; k < 3000; k++) begin
         bit e, u, l;
         logic [7:0]  v2;
         logic [15:0] v4;
         int sel;
         e = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 15) == 0) u = ~up; else u = up;
         l = $urandom_range(0, 19) == 0;
         sel = $urandom_range(0, 2);
         v2 = (sel == 0) ? 8'h99   : (sel == 1) ? 8'h00   : 8'($urandom);
         v4 = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 : 16'($urandom);
         cyc(e, u, l, v2, v4);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
